// File: rtl/blk_9f311d_pkg.sv
// Shared types and helpers for the m_axi read-data tracker.
// Optional build macro: M_AXI_RDATA_TRACKER_OUTREG_EN (registered user output).
package blk_9f311d_pkg;

    typedef struct packed {
        logic       info;
        logic [7:0] len;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    localparam logic [1:0] RRESP_OKAY   = 2'd0;
    localparam logic [1:0] RRESP_EXOKAY = 2'd1;
    localparam logic [1:0] RRESP_SLVERR = 2'd2;
    localparam logic [1:0] RRESP_DECERR = 2'd3;

    localparam int ERR_RLAST = 0;
    localparam int ERR_RESP  = 1;

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/blk_9f311d_ctrl_fifo.sv
// Per-burst control FIFO: no fall-through, registered not-full flag.
// A push into a full FIFO is refused even when a pop happens the same cycle.
module input_loader_r1_ln_iembed_fp32_input_mmap_m_axi_rdata_ctrl_fifo
    import blk_9f311d_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = CTRL_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    output logic                   full_n,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [log2(DEPTH):0]   count
);

    localparam int AW = log2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign push_ok = push & full_n;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_n <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            full_n <= (count_next < FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/blk_9f311d.sv
// Aligns AXI R beats with per-burst control entries, marks request-last, flags errors.
// M_AXI_RDATA_TRACKER_OUTREG_EN: user side driven from a 2-entry skid slice.
module blk_9f311d
    import blk_9f311d_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTSTANDING = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_CTRL_INFO,
    input  logic [7:0]                     in_CTRL_LEN,
    input  logic                           in_CTRL_VALID,
    output logic                           out_CTRL_READY,
    input  logic [DATA_WIDTH-1:0]          in_RDATA,
    input  logic                           in_RLAST,
    input  logic [1:0]                     in_RRESP,
    input  logic                           in_RVALID,
    output logic                           out_RREADY,
    output logic [DATA_WIDTH-1:0]          out_DATA,
    output logic                           out_LAST,
    output logic                           out_VALID,
    input  logic                           in_READY,
    output logic [log2(NUM_OUTSTANDING):0] out_OUTSTANDING,
    output logic [1:0]                     out_ERR
);

    ctrl_t      wr_entry;
    ctrl_t      head;
    logic       empty;
    logic       rready;
    logic       fire;
    logic       head_last;
    logic       resp_err;
    logic [7:0] beat_cnt;
    logic [1:0] err;

    assign wr_entry = '{info: in_CTRL_INFO, len: in_CTRL_LEN};

    input_loader_r1_ln_iembed_fp32_input_mmap_m_axi_rdata_ctrl_fifo #(
        .DEPTH (NUM_OUTSTANDING),
        .WIDTH (CTRL_W)
    ) u_ctrl_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (in_CTRL_VALID),
        .wdata  (wr_entry),
        .full_n (out_CTRL_READY),
        .pop    (fire & head_last),
        .rdata  (head),
        .empty  (empty),
        .count  (out_OUTSTANDING)
    );

    assign head_last = (beat_cnt == head.len);
    assign fire      = in_RVALID & rready;
    assign resp_err  = (in_RRESP == RRESP_SLVERR) | (in_RRESP == RRESP_DECERR);
    assign out_RREADY = rready;
    assign out_ERR    = err;

    // The beat counter, not RLAST, decides where a burst ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
            err      <= '0;
        end else if (fire) begin
            beat_cnt <= head_last ? 8'd0 : beat_cnt + 8'd1;
            if (in_RLAST != head_last) err[ERR_RLAST] <= 1'b1;
            if (resp_err)              err[ERR_RESP]  <= 1'b1;
        end
    end

`ifdef M_AXI_RDATA_TRACKER_OUTREG_EN
    logic [DATA_WIDTH:0] slot [2];
    logic                s_wp;
    logic                s_rp;
    logic [1:0]          s_cnt;
    logic                s_pop;

    assign rready    = ~empty & (s_cnt != 2'd2);
    assign out_VALID = (s_cnt != 2'd0);
    assign s_pop     = out_VALID & in_READY;
    assign out_DATA  = slot[s_rp][DATA_WIDTH-1:0];
    assign out_LAST  = slot[s_rp][DATA_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_wp  <= 1'b0;
            s_rp  <= 1'b0;
            s_cnt <= 2'd0;
        end else begin
            if (fire)  s_wp <= ~s_wp;
            if (s_pop) s_rp <= ~s_rp;
            unique case ({fire, s_pop})
                2'b10:   s_cnt <= s_cnt + 2'd1;
                2'b01:   s_cnt <= s_cnt - 2'd1;
                default: s_cnt <= s_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fire) slot[s_wp] <= {head.info & head_last, in_RDATA};
    end
`else
    assign rready    = in_READY & ~empty;
    assign out_VALID = in_RVALID & ~empty;
    assign out_DATA  = in_RDATA;
    assign out_LAST  = head.info & head_last & ~empty;
`endif

endmodule

// File: doc/blk_9f311d.md
Name: input_loader_r1_ln_iembed_fp32_input_mmap_m_axi_rdata_tracker

Overview:
Read-data stage downstream of the m_axi burst converter. It consumes the converter's per-burst control stream (CTRL_LEN, CTRL_INFO) and aligns it with AXI R-channel beats. It forwards data to the user side with a last-of-request marker. It also detects RLAST/length mismatches and error responses.

Parameters:
DATA_WIDTH, 32, R-channel and user data width in bits
NUM_OUTSTANDING, 16, control FIFO depth (max bursts in flight); power of two, >=2

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
in_CTRL_INFO  in  1  burst is last of its request
in_CTRL_LEN  in  8  AXI len of burst (beats-1)
in_CTRL_VALID  in  1  control entry valid
out_CTRL_READY  out  1  control FIFO not full
in_RDATA  in  DATA_WIDTH  AXI read data
in_RLAST  in  1  AXI RLAST
in_RRESP  in  2  AXI RRESP
in_RVALID  in  1  AXI RVALID
out_RREADY  out  1  AXI RREADY
out_DATA  out  DATA_WIDTH  user data
out_LAST  out  1  last beat of whole request
out_VALID  out  1  user data valid
in_READY  in  1  user ready
out_OUTSTANDING  out  log2(NUM_OUTSTANDING)+1  control entries held
out_ERR  out  2  sticky: [0] RLAST mismatch, [1] SLVERR/DECERR seen

Behaviour:
- Reset (reset==0, async assert, sync deassert by the system): FIFO empty, beat_cnt=0, out_ERR=0, out_OUTSTANDING=0, out_CTRL_READY=1. out_VALID=0 and out_RREADY=0, since FIFO is empty. A reset mid-burst drops all in-flight entries and counts.
- Control FIFO: push on in_CTRL_VALID&out_CTRL_READY. out_CTRL_READY = count<NUM_OUTSTANDING, registered. No fall-through: a push into an empty FIFO is visible at the head the next cycle.
- Simultaneous push and pop keeps count unchanged. When full, push is refused even if a pop happens in the same cycle.
- Data path (default, combinational): out_DATA=in_RDATA. out_VALID=in_RVALID&~empty. out_RREADY=in_READY&~empty.
- No R beat is accepted while the FIFO is empty.
- Beat fire = in_RVALID&out_RREADY. head_last = (beat_cnt==head.len).
- On fire with head_last: pop the FIFO and set beat_cnt<=0. On fire otherwise: beat_cnt<=beat_cnt+1 (8-bit, never wraps because len<=255).
- out_LAST = head.info & head_last & ~empty.
- Error detection on fire:
  - in_RLAST!=head_last sets out_ERR[0].
  - in_RRESP[1] sets out_ERR[1].
  - Errors are sticky until reset. Data is still forwarded, and the counter, not RLAST, decides the burst boundary.
- Latency: zero cycles R-to-user by default. Control entry to first acceptable beat is 1 cycle.
- out_OUTSTANDING equals the FIFO count, updated on the clock edge after push/pop.

Optional Feature:
M_AXI_RDATA_TRACKER_OUTREG_EN
- Defined: out_DATA/out_LAST/out_VALID come from a 2-entry skid register slice. Latency becomes 1 cycle, full throughput is kept, and out_RREADY depends on slice space (not combinationally on in_READY). out_ERR timing is unchanged.
- Undefined: combinational pass-through as above.

Decomposition:
- Shared package holds:
  - ctrl entry typedef {info:1, len:8}
  - the log2 function
  - RRESP encodings (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
  - error bit indices
- One sub-module: input_loader_r1_ln_iembed_fp32_input_mmap_m_axi_rdata_ctrl_fifo, a synchronous FIFO of width 9 and depth NUM_OUTSTANDING with count output.

Test Plan:
- Push {info=1,len=3}, then 4 R beats D0..D3 with RLAST on D3 -> 4 outputs; out_LAST only on D3; FIFO empty after; out_ERR=0.
- Push 16 entries with no R traffic -> out_CTRL_READY=0 after 16th; a 17th push is held; after one len=0 beat, ready returns and out_OUTSTANDING goes 16->15.
- Push {0,1},{1,0}; hold in_READY=0 for 5 cycles mid-burst -> out_RREADY=0 during the stall, no beats lost, out_LAST only on the 3rd beat.
- Push {1,3}; assert RLAST on beat 2 -> out_ERR[0]=1 sticky; out_LAST still on beat 4.
- RRESP=2 on one beat -> out_ERR[1]=1 and data still forwarded. Assert reset mid-burst -> all outputs return to reset values and out_ERR clears.
- RVALID held high with an empty FIFO -> out_RREADY=0, out_VALID=0. Push {1,0} -> beat accepted the following cycle with out_LAST=1.
